// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART receiver
//
// Holds the receiver state enum, default frame geometry and the idle line
// level. When UART_RX_PARITY_EN is defined the enum gains a PARITY state.
package uart_pkg;

  localparam int OVERSAMPLE_DEF = 16;
  localparam int DATA_BITS_DEF  = 8;

  // Serial line level between frames; also the synchronizer reset value so
  // that reset never looks like a start bit edge.
  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchronizer for the asynchronous rx line
//
// Ports:
//   clk   system clock
//   rst   synchronous active-high reset; both flops load RESET_VAL
//   d     asynchronous input
//   q     synchronized output (two clk latency)
module uart_rx_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver with sticky status flags
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   rx_enb      one-clk oversample tick; the FSM only advances on ticks
//   rx          asynchronous serial input, idle high
//   rdy_clr     consumer acknowledge; clears rdy/frame_err/overrun/parity_err
//   data        last byte received with a good stop bit
//   rdy         data valid, sticky until rdy_clr
//   frame_err   stop bit sampled low, sticky until rdy_clr
//   overrun     byte completed while rdy was still set, sticky until rdy_clr
//   parity_err  even-parity mismatch, sticky until rdy_clr
//
// Build option: define UART_RX_PARITY_EN to receive one even-parity bit
// between the last data bit and the stop bit; otherwise parity_err is 0.
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int DATA_BITS  = DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_enb,
  input  logic                 rx,
  input  logic                 rdy_clr,
  output logic [DATA_BITS-1:0] data,
  output logic                 rdy,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 parity_err
);

  localparam int CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  logic rx_s;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_d;
  logic                 rdy_d, frame_err_d, overrun_d;

  uart_rx_sync #(
    .RESET_VAL(IDLE_LEVEL)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (rx),
    .q  (rx_s)
  );

`ifdef UART_RX_PARITY_EN
  logic par_q, par_d;
  logic parity_err_d;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    data_d      = data;
    rdy_d       = rdy;
    frame_err_d = frame_err;
    overrun_d   = overrun;
`ifdef UART_RX_PARITY_EN
    par_d        = par_q;
    parity_err_d = parity_err;
`endif

    // The acknowledge is applied first so that a completion in the same
    // cycle overrides it below.
    if (rdy_clr) begin
      rdy_d       = 1'b0;
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_d = 1'b0;
`endif
    end

    if (rx_enb) begin
      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_d = START;
            cnt_d   = '0;
          end
        end

        START: begin
          if (cnt_q == CNT_HALF) begin
            // Still low at mid start bit: real frame. High: a glitch.
            if (!rx_s) begin
              state_d = DATA;
              cnt_d   = '0;
              idx_d   = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        DATA: begin
          if (cnt_q == CNT_LAST) begin
            shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
            cnt_d   = '0;
            if (idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt_q == CNT_LAST) begin
            par_d   = rx_s;
            cnt_d   = '0;
            state_d = STOP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
`endif

        STOP: begin
          if (cnt_q == CNT_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
            if (rx_s) begin
              data_d = shift_q;
              rdy_d  = 1'b1;
              // An acknowledge arriving with the new byte means the old
              // byte was consumed, so no overrun in that case.
              if (rdy && !rdy_clr) begin
                overrun_d = 1'b1;
              end
`ifdef UART_RX_PARITY_EN
              if (^{shift_q, par_q}) begin
                parity_err_d = 1'b1;
              end
`endif
            end else begin
              frame_err_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      data      <= '0;
      rdy       <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      data      <= data_d;
      rdy       <= rdy_d;
      frame_err <= frame_err_d;
      overrun   <= overrun_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      par_q      <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      par_q      <= par_d;
      parity_err <= parity_err_d;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard testbench for uart_rx
module tb_uart_rx;
  import uart_pkg::*;

  localparam int TICK_CLKS = 14;
  localparam int BIT_CLKS  = TICK_CLKS * 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_enb = 1'b0;
  logic       rx = 1'b1;
  logic       rdy_clr = 1'b0;
  logic [7:0] data;
  logic       rdy, frame_err, overrun, parity_err;

  int tests  = 0;
  int fails  = 0;
  logic mon_en = 1'b0;

  typedef struct packed {
    logic [7:0] d;
    logic       r;
    logic       fe;
    logic       ov;
    logic       pe;
    logic       by_clr;
  } exp_t;

  exp_t exp_q[$];

  uart_rx dut (
    .clk       (clk),
    .rst       (rst),
    .rx_enb    (rx_enb),
    .rx        (rx),
    .rdy_clr   (rdy_clr),
    .data      (data),
    .rdy       (rdy),
    .frame_err (frame_err),
    .overrun   (overrun),
    .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      repeat (TICK_CLKS - 1) @(posedge clk);
      #1 rx_enb = 1'b1;
      @(posedge clk);
      #1 rx_enb = 1'b0;
    end
  end

  // Monitor: every change of the output vector outside reset is one event.
  initial begin
    logic [11:0] prev_vec, cur_vec;
    logic        last_enb, last_clr;
    exp_t        e;
    prev_vec = '0;
    last_enb = 1'b0;
    last_clr = 1'b0;
    forever begin
      @(negedge clk);
      cur_vec = {data, rdy, frame_err, overrun, parity_err};
      if (mon_en && !rst && cur_vec != prev_vec) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_output: got data=%h rdy=%b fe=%b ov=%b pe=%b, required no change",
                   data, rdy, frame_err, overrun, parity_err);
        end else begin
          e = exp_q.pop_front();
          if (cur_vec != {e.d, e.r, e.fe, e.ov, e.pe}) begin
            fails++;
            $display("FAIL output_event: got data=%h rdy=%b fe=%b ov=%b pe=%b, required data=%h rdy=%b fe=%b ov=%b pe=%b",
                     data, rdy, frame_err, overrun, parity_err, e.d, e.r, e.fe, e.ov, e.pe);
          end
          tests++;
          if ((e.by_clr && !last_clr) || (!e.by_clr && !last_enb)) begin
            fails++;
            $display("FAIL event_latency: got tick=%b clr=%b in prior cycle, required %s=1",
                     last_enb, last_clr, e.by_clr ? "clr" : "tick");
          end
        end
      end
      prev_vec = cur_vec;
      last_enb = rx_enb;
      last_clr = rdy_clr;
    end
  end

  task automatic check(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, got, want);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic r, input logic fe,
                      input logic ov, input logic pe, input logic by_clr);
    exp_t e;
    e = '{d: d, r: r, fe: fe, ov: ov, pe: pe, by_clr: by_clr};
    exp_q.push_back(e);
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (BIT_CLKS) @(posedge clk);
    #1;
  endtask

  // abort_bit >= 0 pulses rst in the middle of that data bit.
  task automatic send_frame(input logic [7:0] b, input logic stop_b,
                            input logic par_b, input int abort_bit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == abort_bit) begin
        rx = b[i];
        repeat (BIT_CLKS / 2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (BIT_CLKS / 2 - 3) @(posedge clk);
        #1;
      end else begin
        send_bit(b[i]);
      end
    end
`ifdef UART_RX_PARITY_EN
    send_bit(par_b);
`else
    if (par_b) rx = 1'b1;
`endif
    send_bit(stop_b);
    rx = 1'b1;
    repeat (2 * BIT_CLKS) @(posedge clk);
    #1;
  endtask

  task automatic ack();
    @(posedge clk);
    #1 rdy_clr = 1'b1;
    @(posedge clk);
    #1 rdy_clr = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic pulse_rst();
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    int budget;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    check("reset_outputs", int'({data, rdy, frame_err, overrun, parity_err}), 0);
    check("reset_state", int'(dut.state_q), int'(IDLE));
    mon_en = 1'b1;

    // Good 8N1 frame 0xA5 (even parity bit 0), then acknowledge.
    push(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'hA5, 1'b1, 1'b0, -1);
    push(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    ack();

    // Three-tick low glitch must not start a frame.
    rx = 1'b0;
    repeat (3 * TICK_CLKS) @(posedge clk);
    #1 rx = 1'b1;
    repeat (20 * TICK_CLKS) @(posedge clk);
    #1;
    check("glitch_state", int'(dut.state_q), int'(IDLE));
    check("glitch_rdy", int'(rdy), 0);
    check("glitch_frame_err", int'(frame_err), 0);
    check("glitch_overrun", int'(overrun), 0);

    // Bad stop bit after reset: frame_err only, data stays 0x00.
    pulse_rst();
    check("data_after_rst", int'(data), 0);
    push(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b0, 1'b0, -1);
    push(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    ack();

    // Two frames without acknowledge: overrun, data overwritten.
    push(8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h11, 1'b1, 1'b0, -1);
    push(8'h22, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0, -1);
    push(8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    ack();

    // Reset during bit 4 of 0xFF: frame abandoned, then 0x5A received cleanly.
    send_frame(8'hFF, 1'b1, 1'b0, 4);
    check("abort_rdy", int'(rdy), 0);
    push(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h5A, 1'b1, 1'b0, -1);
    push(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    ack();

`ifdef UART_RX_PARITY_EN
    push(8'h03, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h03, 1'b1, 1'b1, -1);
    push(8'h03, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    ack();
    push(8'h03, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h03, 1'b1, 1'b0, -1);
    push(8'h03, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    ack();
`endif

    budget = 5000;
    while (exp_q.size() != 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    #1;
    check("expected_queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
